// File: rtl/softmax_norm_stage.sv
`default_nettype none
// ============================================================================
// Module  : softmax_norm_stage
// Brief   : Buffers a row of exponent values and their sum, then emits each
//           value as floor(e_i * 2^OUT_W / sum) using a bit-serial divider.
// Rev     : 1.0
// ============================================================================
module softmax_norm_stage #(
    parameter int N_SCORES = 4,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_vld,
    output logic              s_rdy,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_vld,
    input  logic              m_rdy,
    output logic              m_last,
    output logic              busy
);
    localparam int SUM_W = DATA_W + $clog2(N_SCORES);
    localparam int IDX_W = $clog2(N_SCORES);
    localparam int CNT_W = $clog2(OUT_W + 2);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DIVIDE  = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] row_q [N_SCORES];
    logic [DATA_W-1:0] row_d [N_SCORES];
    logic [SUM_W-1:0]  rem_q, rem_d;
    logic [OUT_W:0]    dvd_q, dvd_d;
    logic [OUT_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  m_data_q, m_data_d;

    logic [IDX_W-1:0]  w_load_idx;
    logic [DATA_W-1:0] w_load_val;
    logic [SUM_W:0]    w_trial;
    logic              w_take;
    logic [OUT_W:0]    w_quotient;

    assign w_load_idx = (state_q == ST_COLLECT) ? '0 : idx_q + IDX_W'(1);
    assign w_load_val = row_q[w_load_idx];
    assign w_trial    = {rem_q, dvd_q[OUT_W]};
    // A zero sum never subtracts, so an all-zero row yields zero quotients.
    assign w_take     = (sum_q != '0) && (w_trial >= {1'b0, sum_q});
    assign w_quotient = {quo_q, w_take};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        row_d    = row_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        case (state_q)
            ST_COLLECT: begin
                if (s_vld) begin
                    row_d[idx_q] = s_data;
                    sum_d        = sum_q + SUM_W'(s_data);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_DIVIDE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DIVIDE: begin
                rem_d = w_take ? SUM_W'(w_trial - {1'b0, sum_q}) : w_trial[SUM_W-1:0];
                dvd_d = {dvd_q[OUT_W-1:0], 1'b0};
                quo_d = w_quotient[OUT_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_EMIT;
                    m_data_d = w_quotient[OUT_W] ? '1 : w_quotient[OUT_W-1:0];
                end
            end
            ST_EMIT: begin
                if (m_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_COLLECT;
                        idx_d   = '0;
                        sum_d   = '0;
                    end else begin
                        state_d = ST_DIVIDE;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        // Since e_i <= sum, the top DATA_W-1 dividend bits are already below
        // sum and seed the remainder; only OUT_W+1 bits remain to shift in.
        if ((state_d == ST_DIVIDE) && (state_q != ST_DIVIDE)) begin
            rem_d = SUM_W'(w_load_val >> 1);
            dvd_d = {w_load_val[0], OUT_W'(0)};
            quo_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_COLLECT;
            idx_q    <= '0;
            sum_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
        end
    end

    always_ff @(posedge clk) begin
        row_q <= row_d;
    end

    assign s_rdy  = (state_q == ST_COLLECT);
    assign busy   = (state_q != ST_COLLECT);
    assign m_vld  = (state_q == ST_EMIT);
    assign m_last = (state_q == ST_EMIT) && (idx_q == LAST_IDX);
    assign m_data = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_norm_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_softmax_norm_stage
// Brief   : Scenario tasks drive rows into softmax_norm_stage and compare the
//           normalised outputs against an arithmetic reference model.
// Rev     : 1.0
// ============================================================================
module tb_softmax_norm_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_vld;
    logic       s_rdy;
    logic [7:0] m_data;
    logic       m_vld;
    logic       m_rdy;
    logic       m_last;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] row_in   [8];
    logic [7:0] got_data [8];
    logic       got_last [8];
    int         exp_v    [8];
    int         lat, stab_err, rdy_err, ovl_err;
    bit         tmo;

    softmax_norm_stage #(.N_SCORES(4), .DATA_W(8), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
        .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy),
        .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_norm(input int e, input int s);
        int q;
        if (s == 0) return 0;
        q = (e * 256) / s;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic int row_sum(input int r);
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(row_in[4*r+k]);
        return s;
    endfunction

    // Drives nrows rows from row_in with random s_vld gaps and a fixed
    // per-element consumer stall, recording outputs and protocol errors.
    task automatic run_rows(input int nrows, input int gap_pct, input int stall);
        int si = 0, ri = 0, cyc = 0, acc_cyc = -1, st = 0;
        logic [7:0] hold_d;
        logic       hold_l;
        bit s_x, m_x;
        lat = -1; stab_err = 0; rdy_err = 0; ovl_err = 0;
        hold_d = '0; hold_l = 1'b0;
        while (ri < nrows*4 && cyc < 2000) begin
            s_vld  = (si < nrows*4) && ($urandom_range(0, 99) >= gap_pct);
            s_data = (si < nrows*4) ? row_in[si] : 8'h00;
            if (s_rdy !== !busy) rdy_err++;
            if (m_vld) begin
                if (st == 0) begin
                    hold_d = m_data;
                    hold_l = m_last;
                end else if (m_data !== hold_d || m_last !== hold_l) begin
                    stab_err++;
                end
                m_rdy = (st >= stall);
                st++;
            end else begin
                m_rdy = (stall == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            end
            s_x = s_vld && s_rdy;
            m_x = m_vld && m_rdy;
            if (s_x && (si/4 != ri/4)) ovl_err++;
            if (m_x) begin
                got_data[ri] = m_data;
                got_last[ri] = m_last;
            end
            @(posedge clk); #1;
            cyc++;
            if (s_x) begin
                si++;
                if (si == 4) acc_cyc = cyc;
            end
            if (m_x) begin
                ri++;
                st = 0;
            end
            if (lat < 0 && acc_cyc >= 0 && m_vld) lat = cyc - acc_cyc;
        end
        tmo   = (ri < nrows*4);
        s_vld = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (m_vld !== 1'b0)   begin n_fail++; $display("FAIL reset_m_vld: got %b expected 0", m_vld); end
        n_checks++; if (m_last !== 1'b0)  begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (s_rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_s_rdy: got %b expected 1", s_rdy); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_uniform;
        for (int i = 0; i < 4; i++) row_in[i] = 8'd64;
        run_rows(1, 0, 0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL uniform_timeout: got %b expected 0", tmo); end
        n_checks++; if (lat !== 9)    begin n_fail++; $display("FAIL uniform_latency: got %0d expected 9", lat); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_data[i] !== 8'd64) begin n_fail++; $display("FAIL uniform_data[%0d]: got %0d expected 64", i, got_data[i]); end
            n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL uniform_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
        end
    endtask

    task automatic test_values;
        row_in[0] = 8'd10;  row_in[1] = 8'd20; row_in[2] = 8'd30; row_in[3] = 8'd40;
        row_in[4] = 8'd255; row_in[5] = 8'd0;  row_in[6] = 8'd0;  row_in[7] = 8'd0;
        exp_v[0] = 25;  exp_v[1] = 51; exp_v[2] = 76; exp_v[3] = 102;
        exp_v[4] = 255; exp_v[5] = 0;  exp_v[6] = 0;  exp_v[7] = 0;
        run_rows(2, 0, 0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL values_timeout: got %b expected 0", tmo); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (got_data[i] !== 8'(exp_v[i])) begin n_fail++; $display("FAIL values_data[%0d]: got %0d expected %0d", i, got_data[i], exp_v[i]); end
            n_checks++; if (got_last[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL values_last[%0d]: got %b expected %b", i, got_last[i], (i % 4 == 3)); end
        end
    endtask

    task automatic test_zero;
        for (int i = 0; i < 4; i++) row_in[i] = 8'd0;
        run_rows(1, 0, 0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got %b expected 0", tmo); end
        n_checks++; if (lat !== 9)    begin n_fail++; $display("FAIL zero_latency: got %0d expected 9", lat); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_data[i] !== 8'd0) begin n_fail++; $display("FAIL zero_data[%0d]: got %0d expected 0", i, got_data[i]); end
        end
    endtask

    task automatic test_stall;
        row_in[0] = 8'd10; row_in[1] = 8'd20; row_in[2] = 8'd30; row_in[3] = 8'd40;
        exp_v[0] = 25; exp_v[1] = 51; exp_v[2] = 76; exp_v[3] = 102;
        run_rows(1, 50, 5);
        n_checks++; if (tmo !== 1'b0)   begin n_fail++; $display("FAIL stall_timeout: got %b expected 0", tmo); end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes expected 0", stab_err); end
        n_checks++; if (rdy_err !== 0)  begin n_fail++; $display("FAIL stall_s_rdy_busy: got %0d errors expected 0", rdy_err); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_data[i] !== 8'(exp_v[i])) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got_data[i], exp_v[i]); end
            n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
        end
    endtask

    task automatic test_reset_abort;
        int si = 0, cyc = 0;
        bit x;
        logic [7:0] vals [4];
        vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40;
        while (si < 4 && cyc < 100) begin
            s_vld  = 1'b1;
            s_data = vals[si];
            x      = s_rdy;
            @(posedge clk); #1;
            cyc++;
            if (x) si++;
        end
        s_vld = 1'b0;
        cyc   = 0;
        while (!m_vld && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (m_vld !== 1'b1) begin n_fail++; $display("FAIL abort_first_vld: got %b expected 1", m_vld); end
        m_rdy = 1'b1;
        @(posedge clk); #1;
        m_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL abort_mid_divide_busy: got %b expected 1", busy); end
        n_checks++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL abort_mid_divide_vld: got %b expected 0", m_vld); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (m_vld !== 1'b0)   begin n_fail++; $display("FAIL abort_m_vld: got %b expected 0", m_vld); end
        n_checks++; if (s_rdy !== 1'b1)   begin n_fail++; $display("FAIL abort_s_rdy: got %b expected 1", s_rdy); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL abort_m_data: got %0d expected 0", m_data); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) row_in[i] = 8'd1;
        run_rows(1, 30, 2);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: got %b expected 0", tmo); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_data[i] !== 8'd64) begin n_fail++; $display("FAIL abort_data[%0d]: got %0d expected 64", i, got_data[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int e;
        for (int i = 0; i < 8; i++) row_in[i] = 8'($urandom_range(0, 255));
        run_rows(2, 0, 0);
        n_checks++; if (tmo !== 1'b0)  begin n_fail++; $display("FAIL b2b_timeout: got %b expected 0", tmo); end
        n_checks++; if (ovl_err !== 0) begin n_fail++; $display("FAIL b2b_row_overlap: got %0d early accepts expected 0", ovl_err); end
        for (int i = 0; i < 8; i++) begin
            e = ref_norm(int'(row_in[i]), row_sum(i / 4));
            n_checks++; if (got_data[i] !== 8'(e)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, got_data[i], e); end
            n_checks++; if (got_last[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, got_last[i], (i % 4 == 3)); end
        end
    endtask

    task automatic test_random;
        int e;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++)
                row_in[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            run_rows(1, 30, int'($urandom_range(0, 3)));
            n_checks++; if (tmo !== 1'b0)   begin n_fail++; $display("FAIL random_timeout row %0d: got %b expected 0", r, tmo); end
            n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL random_stability row %0d: got %0d expected 0", r, stab_err); end
            for (int i = 0; i < 4; i++) begin
                e = ref_norm(int'(row_in[i]), row_sum(0));
                n_checks++; if (got_data[i] !== 8'(e)) begin n_fail++; $display("FAIL random_data row %0d [%0d]: got %0d expected %0d", r, i, got_data[i], e); end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        s_vld  = 1'b0;
        s_data = 8'h00;
        m_rdy  = 1'b0;
        test_reset;
        test_uniform;
        test_values;
        test_zero;
        test_stall;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
